// File: rtl/cpu_pipe_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pipe_pkg
// Description : Shared types and constants for the pipeline hazard
//               controller (FSM states, forwarding-select encodings).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pipe_pkg;

  // Controller states; the encoding is visible on o_state
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  // Operand source selects for the decode stage
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_X  = 2'd2;

  // Execute-stage producer is younger than rf-write, so it wins
  function automatic logic [1:0] fwd_sel(input logic x_hit, input logic w_hit);
    if (x_hit)      return FWD_X;
    else if (w_hit) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_pipe_hazard_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pipe_hazard_if
// Description : Stage-status inputs and control outputs of the pipeline
//               hazard controller. slave = controller, master = pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_pipe_hazard_if #(
  parameter int NUM_REGS = 8,
  parameter int PERF_W   = 32
);
  localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                 i_d_valid;
  logic [REG_IDX_W-1:0] i_d_rx;
  logic [REG_IDX_W-1:0] i_d_ry;
  logic                 i_d_uses_rx;
  logic                 i_d_uses_ry;
  logic                 i_x_valid;
  logic                 i_x_wr_en;
  logic [REG_IDX_W-1:0] i_x_wr_idx;
  logic                 i_x_is_mem;
  logic                 i_x_is_load;
  logic                 i_x_br_taken;
  logic                 i_w_valid;
  logic                 i_w_wr_en;
  logic [REG_IDX_W-1:0] i_w_wr_idx;
  logic                 i_mem_ack;

  logic                 o_pc_ld;
  logic                 o_decode_ld;
  logic                 o_execute_ld;
  logic                 o_rfwrite_ld;
  logic                 o_flush_f;
  logic                 o_flush_d;
  logic                 o_bubble_w;
  logic                 o_pc_sel_target;
  logic [1:0]           o_rx_fwd_sel;
  logic [1:0]           o_ry_fwd_sel;
  logic                 o_mem_req;
  logic                 o_mem_err;
  logic [1:0]           o_state;
  logic [PERF_W-1:0]    o_stall_cnt;
  logic [PERF_W-1:0]    o_flush_cnt;
  logic [PERF_W-1:0]    o_memwait_cnt;

  modport slave (
    input  i_d_valid, i_d_rx, i_d_ry, i_d_uses_rx, i_d_uses_ry,
           i_x_valid, i_x_wr_en, i_x_wr_idx, i_x_is_mem, i_x_is_load, i_x_br_taken,
           i_w_valid, i_w_wr_en, i_w_wr_idx, i_mem_ack,
    output o_pc_ld, o_decode_ld, o_execute_ld, o_rfwrite_ld,
           o_flush_f, o_flush_d, o_bubble_w, o_pc_sel_target,
           o_rx_fwd_sel, o_ry_fwd_sel, o_mem_req, o_mem_err, o_state,
           o_stall_cnt, o_flush_cnt, o_memwait_cnt
  );

  modport master (
    output i_d_valid, i_d_rx, i_d_ry, i_d_uses_rx, i_d_uses_ry,
           i_x_valid, i_x_wr_en, i_x_wr_idx, i_x_is_mem, i_x_is_load, i_x_br_taken,
           i_w_valid, i_w_wr_en, i_w_wr_idx, i_mem_ack,
    input  o_pc_ld, o_decode_ld, o_execute_ld, o_rfwrite_ld,
           o_flush_f, o_flush_d, o_bubble_w, o_pc_sel_target,
           o_rx_fwd_sel, o_ry_fwd_sel, o_mem_req, o_mem_err, o_state,
           o_stall_cnt, o_flush_cnt, o_memwait_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cpu_pipe_hazard_timer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_wait_timer
// Description : Counts consecutive unanswered memory-wait cycles and flags
//               the cycle in which the count reaches MEM_TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_en,
  output logic      o_timeout
);
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // Count while enabled; any cycle without enable (ack, not waiting) clears
  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt != C_LIMIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_timeout = i_en && (r_cnt == C_LIMIT);
endmodule
`default_nettype wire

// File: rtl/cpu_pipe_hazard.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pipe_hazard
// Description : Pipeline advance / hazard controller for the 4-stage CPU:
//               stage load enables, flushes, bubbles, operand forwarding
//               selects and the execute-stage memory wait/timeout handshake.
//               Optional macro CPU_PIPE_PERF_EN enables the saturating
//               stall/flush/mem-wait performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_pipe_hazard
  import cpu_pipe_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_W      = 32
) (
  input  wire logic       clk,
  input  wire logic       reset,
  cpu_pipe_hazard_if.slave bus
);
  localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e r_state;
  logic   r_mem_err;

  logic [REG_IDX_W-1:0] w_d_rx, w_d_ry, w_x_idx, w_w_idx;
  logic w_in_wait, w_in_halt;
  logic w_mem_req, w_mem_pend, w_branch, w_load_use, w_timeout;
  logic w_pc_ld, w_decode_ld, w_execute_ld, w_rfwrite_ld;
  logic w_flush_f, w_flush_d, w_bubble_w, w_pc_sel;

  assign w_d_rx  = bus.i_d_rx;
  assign w_d_ry  = bus.i_d_ry;
  assign w_x_idx = bus.i_x_wr_idx;
  assign w_w_idx = bus.i_w_wr_idx;

  assign w_in_wait = (r_state == ST_MEM_WAIT);
  assign w_in_halt = (r_state == ST_HALT);

  // A memory op blocks the pipe in any non-halted cycle it is not acked
  assign w_mem_req  = !w_in_halt && bus.i_x_valid && bus.i_x_is_mem;
  assign w_mem_pend = w_mem_req && !bus.i_mem_ack;
  // A branch alongside a memory op is illegal; the memory op takes precedence
  assign w_branch   = bus.i_x_valid && bus.i_x_br_taken && !bus.i_x_is_mem;
  assign w_load_use = bus.i_x_valid && bus.i_x_is_load && bus.i_x_wr_en && bus.i_d_valid &&
                      ((bus.i_d_uses_rx && (w_d_rx == w_x_idx)) ||
                       (bus.i_d_uses_ry && (w_d_ry == w_x_idx)));

  // Loads are not forwardable from execute (data not yet returned)
  assign bus.o_rx_fwd_sel = fwd_sel(
      bus.i_x_valid && bus.i_x_wr_en && !bus.i_x_is_load && (w_x_idx == w_d_rx),
      bus.i_w_valid && bus.i_w_wr_en && (w_w_idx == w_d_rx));
  assign bus.o_ry_fwd_sel = fwd_sel(
      bus.i_x_valid && bus.i_x_wr_en && !bus.i_x_is_load && (w_x_idx == w_d_ry),
      bus.i_w_valid && bus.i_w_wr_en && (w_w_idx == w_d_ry));

  cpu_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_in_wait && w_mem_pend),
    .o_timeout (w_timeout)
  );

  // Stage control resolution: reset > halt > mem wait > branch > load-use
  always_comb begin
    w_pc_ld      = 1'b1;
    w_decode_ld  = 1'b1;
    w_execute_ld = 1'b1;
    w_rfwrite_ld = 1'b1;
    w_flush_f    = 1'b0;
    w_flush_d    = 1'b0;
    w_bubble_w   = 1'b0;
    w_pc_sel     = 1'b0;
    if (reset) begin
      w_flush_f  = 1'b1;
      w_flush_d  = 1'b1;
      w_bubble_w = 1'b1;
    end else if (w_in_halt) begin
      w_pc_ld      = 1'b0;
      w_decode_ld  = 1'b0;
      w_execute_ld = 1'b0;
      w_rfwrite_ld = 1'b0;
    end else if (w_mem_pend) begin
      w_pc_ld      = 1'b0;
      w_decode_ld  = 1'b0;
      w_execute_ld = 1'b0;
      w_bubble_w   = 1'b1;
    end else if (w_branch) begin
      w_pc_sel  = 1'b1;
      w_flush_f = 1'b1;
      w_flush_d = 1'b1;
    end else if (w_load_use) begin
      w_pc_ld     = 1'b0;
      w_decode_ld = 1'b0;
      w_flush_d   = 1'b1;
    end
  end

  // Controller FSM with sticky timeout error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_mem_err <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_pend) r_state <= ST_MEM_WAIT;
        end
        ST_MEM_WAIT: begin
          if (!w_mem_pend) begin
            r_state <= ST_RUN;
          end else if (w_timeout) begin
            r_state   <= ST_HALT;
            r_mem_err <= 1'b1;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.o_pc_ld         = w_pc_ld;
  assign bus.o_decode_ld     = w_decode_ld;
  assign bus.o_execute_ld    = w_execute_ld;
  assign bus.o_rfwrite_ld    = w_rfwrite_ld;
  assign bus.o_flush_f       = w_flush_f;
  assign bus.o_flush_d       = w_flush_d;
  assign bus.o_bubble_w      = w_bubble_w;
  assign bus.o_pc_sel_target = w_pc_sel;
  assign bus.o_mem_req       = !reset && w_mem_req;
  assign bus.o_mem_err       = r_mem_err;
  assign bus.o_state         = r_state;

`ifdef CPU_PIPE_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt, r_memwait_cnt;
  logic w_stall_evt, w_flush_evt, w_memwait_evt;

  assign w_stall_evt   = !w_in_halt && !w_mem_pend && !w_branch && w_load_use;
  assign w_flush_evt   = !w_in_halt && !w_mem_pend && w_branch;
  assign w_memwait_evt = w_in_wait && w_mem_pend;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_memwait_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != {PERF_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (w_flush_evt && (r_flush_cnt != {PERF_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + PERF_W'(1);
      if (w_memwait_evt && (r_memwait_cnt != {PERF_W{1'b1}}))
        r_memwait_cnt <= r_memwait_cnt + PERF_W'(1);
    end
  end

  assign bus.o_stall_cnt   = r_stall_cnt;
  assign bus.o_flush_cnt   = r_flush_cnt;
  assign bus.o_memwait_cnt = r_memwait_cnt;
`else
  assign bus.o_stall_cnt   = {PERF_W{1'b0}};
  assign bus.o_flush_cnt   = {PERF_W{1'b0}};
  assign bus.o_memwait_cnt = {PERF_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_pipe_hazard.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_pipe_hazard
// Description : Self-checking bench for cpu_pipe_hazard: directed scenarios
//               with literal expectations, then randomized stimulus compared
//               every cycle against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_pipe_hazard;
  localparam int TIMEOUT = 4;
  localparam int PW      = 32;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  cpu_pipe_hazard_if #(.NUM_REGS(8), .PERF_W(PW)) bus ();

  cpu_pipe_hazard #(.NUM_REGS(8), .MEM_TIMEOUT(TIMEOUT), .PERF_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: 0 run, 1 waiting on memory, 2 halted
  int     m_st;
  int     m_wait;
  bit     m_err;
  longint m_stall, m_flush, m_memwait;
  bit     ev_stall, ev_flush, ev_memwait, ev_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input int s);
    if (bus.i_x_valid && bus.i_x_wr_en && !bus.i_x_is_load && int'(bus.i_x_wr_idx) == s) return 2'd2;
    if (bus.i_w_valid && bus.i_w_wr_en && int'(bus.i_w_wr_idx) == s) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_compare();
    bit halt, req, br, lu;
    bit pc, dc, ex, rf, ff, fd, bw, sel;
    halt = (m_st == 2);
    req  = !halt && bus.i_x_valid && bus.i_x_is_mem;
    ev_pend = req && !bus.i_mem_ack;
    br   = bus.i_x_valid && bus.i_x_br_taken && !bus.i_x_is_mem;
    lu   = bus.i_x_valid && bus.i_x_is_load && bus.i_x_wr_en && bus.i_d_valid &&
           ((bus.i_d_uses_rx && bus.i_d_rx == bus.i_x_wr_idx) ||
            (bus.i_d_uses_ry && bus.i_d_ry == bus.i_x_wr_idx));
    {pc, dc, ex, rf} = 4'b1111;
    {ff, fd, bw, sel} = 4'b0000;
    if (reset) {ff, fd, bw} = 3'b111;
    else if (halt) {pc, dc, ex, rf} = 4'b0000;
    else if (ev_pend) begin {pc, dc, ex} = 3'b000; bw = 1'b1; end
    else if (br) {sel, ff, fd} = 3'b111;
    else if (lu) begin {pc, dc} = 2'b00; fd = 1'b1; end
    ev_stall   = !halt && !ev_pend && !br && lu;
    ev_flush   = !halt && !ev_pend && br;
    ev_memwait = (m_st == 1) && ev_pend;
    check("pc_ld", bus.o_pc_ld, pc);
    check("decode_ld", bus.o_decode_ld, dc);
    check("execute_ld", bus.o_execute_ld, ex);
    check("rfwrite_ld", bus.o_rfwrite_ld, rf);
    check("flush_f", bus.o_flush_f, ff);
    check("flush_d", bus.o_flush_d, fd);
    check("bubble_w", bus.o_bubble_w, bw);
    check("pc_sel_target", bus.o_pc_sel_target, sel);
    check("rx_fwd_sel", bus.o_rx_fwd_sel, exp_fwd(int'(bus.i_d_rx)));
    check("ry_fwd_sel", bus.o_ry_fwd_sel, exp_fwd(int'(bus.i_d_ry)));
    check("mem_req", bus.o_mem_req, req && !reset);
    check("mem_err", bus.o_mem_err, m_err);
    check("state", bus.o_state, 64'(m_st));
`ifdef CPU_PIPE_PERF_EN
    check("stall_cnt", bus.o_stall_cnt, m_stall);
    check("flush_cnt", bus.o_flush_cnt, m_flush);
    check("memwait_cnt", bus.o_memwait_cnt, m_memwait);
`else
    check("stall_cnt", bus.o_stall_cnt, 0);
    check("flush_cnt", bus.o_flush_cnt, 0);
    check("memwait_cnt", bus.o_memwait_cnt, 0);
`endif
  endtask

  task automatic model_update();
    longint sat;
    sat = (64'd1 << PW) - 1;
    if (reset) begin
      m_st = 0; m_wait = 0; m_err = 0;
      m_stall = 0; m_flush = 0; m_memwait = 0;
    end else begin
      if (ev_stall && m_stall < sat) m_stall++;
      if (ev_flush && m_flush < sat) m_flush++;
      if (ev_memwait && m_memwait < sat) m_memwait++;
      if (m_st == 0) begin
        if (ev_pend) begin m_st = 1; m_wait = 0; end
      end else if (m_st == 1) begin
        if (!ev_pend) m_st = 0;
        else if (m_wait == TIMEOUT) begin m_st = 2; m_err = 1; end
        else m_wait++;
      end
    end
  endtask

  // One clock: compare mid-low-phase, advance model at the edge
  task automatic cycle();
    #1;
    model_compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.i_d_valid = 0; bus.i_d_rx = 0; bus.i_d_ry = 0;
    bus.i_d_uses_rx = 0; bus.i_d_uses_ry = 0;
    bus.i_x_valid = 0; bus.i_x_wr_en = 0; bus.i_x_wr_idx = 0;
    bus.i_x_is_mem = 0; bus.i_x_is_load = 0; bus.i_x_br_taken = 0;
    bus.i_w_valid = 0; bus.i_w_wr_en = 0; bus.i_w_wr_idx = 0;
    bus.i_mem_ack = 0;
  endtask

  task automatic rand_inputs();
    reset = ($urandom_range(0, 63) == 0);
    bus.i_d_valid   = 1'($urandom_range(0, 1));
    bus.i_d_rx      = 3'($urandom_range(0, 3));
    bus.i_d_ry      = 3'($urandom_range(0, 3));
    bus.i_d_uses_rx = 1'($urandom_range(0, 1));
    bus.i_d_uses_ry = 1'($urandom_range(0, 1));
    bus.i_x_valid   = ($urandom_range(0, 3) != 0);
    bus.i_x_wr_en   = 1'($urandom_range(0, 1));
    bus.i_x_wr_idx  = 3'($urandom_range(0, 3));
    bus.i_x_is_load = ($urandom_range(0, 3) == 0);
    bus.i_x_is_mem  = bus.i_x_is_load || ($urandom_range(0, 4) == 0);
    bus.i_x_br_taken = (!bus.i_x_is_mem && $urandom_range(0, 3) == 0) || ($urandom_range(0, 31) == 0);
    bus.i_w_valid   = 1'($urandom_range(0, 1));
    bus.i_w_wr_en   = 1'($urandom_range(0, 1));
    bus.i_w_wr_idx  = 3'($urandom_range(0, 3));
    bus.i_mem_ack   = ($urandom_range(0, 9) < 4);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_st = 0; m_wait = 0; m_err = 0;
    m_stall = 0; m_flush = 0; m_memwait = 0;
    ev_stall = 0; ev_flush = 0; ev_memwait = 0; ev_pend = 0;
    reset = 1'b1;
    idle();
    // Bring the DUT out of its unknown power-up state before comparing
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);

    // Reset cycle with a memory op present: request must stay low
    bus.i_x_valid = 1; bus.i_x_is_mem = 1;
    #1;
    check("rst_mem_req", bus.o_mem_req, 0);
    check("rst_flush_f", bus.o_flush_f, 1);
    check("rst_pc_ld", bus.o_pc_ld, 1);
    cycle();
    reset = 1'b0;
    idle();
    #1;
    check("rel_state", bus.o_state, 0);
    check("rel_err", bus.o_mem_err, 0);
    cycle();

    // Forwarding priority on rx=r3
    bus.i_d_valid = 1; bus.i_d_uses_rx = 1; bus.i_d_rx = 3;
    bus.i_x_valid = 1; bus.i_x_wr_en = 1; bus.i_x_wr_idx = 3;
    bus.i_w_valid = 1; bus.i_w_wr_en = 1; bus.i_w_wr_idx = 3;
    #1; check("fwd_x", bus.o_rx_fwd_sel, 2); cycle();
    bus.i_x_wr_en = 0;
    #1; check("fwd_w", bus.o_rx_fwd_sel, 1); cycle();
    bus.i_w_wr_en = 0;
    #1; check("fwd_rf", bus.o_rx_fwd_sel, 0); cycle();

    // Load-use on ry=r5 with zero-wait memory
    idle();
    bus.i_d_valid = 1; bus.i_d_uses_ry = 1; bus.i_d_ry = 5;
    bus.i_x_valid = 1; bus.i_x_wr_en = 1; bus.i_x_wr_idx = 5;
    bus.i_x_is_mem = 1; bus.i_x_is_load = 1; bus.i_mem_ack = 1;
    #1;
    check("lu_pc_ld", bus.o_pc_ld, 0);
    check("lu_decode_ld", bus.o_decode_ld, 0);
    check("lu_flush_d", bus.o_flush_d, 1);
    check("lu_execute_ld", bus.o_execute_ld, 1);
    cycle();
    bus.i_x_valid = 0; bus.i_x_is_mem = 0; bus.i_x_is_load = 0; bus.i_mem_ack = 0;
    bus.i_w_valid = 1; bus.i_w_wr_en = 1; bus.i_w_wr_idx = 5;
    #1;
    check("lu2_ry_fwd", bus.o_ry_fwd_sel, 1);
    check("lu2_pc_ld", bus.o_pc_ld, 1);
    cycle();

    // Store acknowledged after three wait-state cycles
    idle();
    bus.i_x_valid = 1; bus.i_x_is_mem = 1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_state", bus.o_state, 1);
      check("st_bubble_w", bus.o_bubble_w, 1);
      check("st_mem_req", bus.o_mem_req, 1);
      check("st_pc_ld", bus.o_pc_ld, 0);
      cycle();
    end
    bus.i_mem_ack = 1;
    #1;
    check("ack_pc_ld", bus.o_pc_ld, 1);
    check("ack_execute_ld", bus.o_execute_ld, 1);
    cycle();
    idle();
    #1; check("ack_state_run", bus.o_state, 0);
    cycle();

    // Branch wins over load-use
    bus.i_d_valid = 1; bus.i_d_uses_rx = 1; bus.i_d_rx = 2;
    bus.i_x_valid = 1; bus.i_x_wr_en = 1; bus.i_x_wr_idx = 2;
    bus.i_x_is_load = 1; bus.i_x_br_taken = 1;
    #1;
    check("br_sel", bus.o_pc_sel_target, 1);
    check("br_flush_f", bus.o_flush_f, 1);
    check("br_flush_d", bus.o_flush_d, 1);
    check("br_pc_ld", bus.o_pc_ld, 1);
    check("br_decode_ld", bus.o_decode_ld, 1);
    cycle();
    idle();
`ifdef CPU_PIPE_PERF_EN
    #1;
    check("perf_stall", bus.o_stall_cnt, 1);
    check("perf_flush", bus.o_flush_cnt, 1);
    check("perf_memwait", bus.o_memwait_cnt, 3);
`endif
    cycle();

    // Memory timeout leads to HALT; only reset recovers
    bus.i_x_valid = 1; bus.i_x_is_mem = 1;
    cycle();
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      #1; check("to_waiting", bus.o_state, 1);
      cycle();
    end
    #1;
    check("to_halt", bus.o_state, 2);
    check("to_err", bus.o_mem_err, 1);
    check("to_pc_ld", bus.o_pc_ld, 0);
    check("to_rfwrite_ld", bus.o_rfwrite_ld, 0);
    check("to_mem_req", bus.o_mem_req, 0);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle();
    #1;
    check("to_rst_state", bus.o_state, 0);
    check("to_rst_err", bus.o_mem_err, 0);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cpu_pipe_hazard.md
Name: cpu_pipe_hazard

Overview:
Parametrised hazard, stall and forwarding controller for the 4-stage (fetch/decode/execute/rf-write) 16-bit CPU pipeline. It generates per-stage load enables, flushes and bubbles, and decode-stage operand forwarding selects. It also runs a wait-state memory handshake with timeout for execute-stage load/store.
- Existing stage controllers keep instruction-specific decoding; this block owns pipeline advance and hazard resolution only.

Parameters:
NUM_REGS, 8, number of architectural registers; REG_IDX_W = max(1, $clog2(NUM_REGS))
MEM_TIMEOUT, 255, max wait cycles for i_mem_ack before error; counter width = $clog2(MEM_TIMEOUT+1)
PERF_W, 32, width of performance counters (used only with optional feature)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
i_d_valid  in  1  decode stage holds a real instruction
i_d_rx / i_d_ry  in  REG_IDX_W each  decode source register indices
i_d_uses_rx / i_d_uses_ry  in  1 each  decode instruction reads rx / ry
i_x_valid  in  1  execute stage holds a real instruction
i_x_wr_en  in  1  execute instruction writes a register
i_x_wr_idx  in  REG_IDX_W  execute destination index
i_x_is_mem  in  1  execute instruction is load or store
i_x_is_load  in  1  execute instruction is a load (implies is_mem)
i_x_br_taken  in  1  execute resolved a taken branch/jump
i_w_valid, i_w_wr_en  in  1 each  rf-write stage valid / writes register
i_w_wr_idx  in  REG_IDX_W  rf-write destination index
i_mem_ack  in  1  memory completes the current request this cycle
o_pc_ld, o_decode_ld, o_execute_ld, o_rfwrite_ld  out  1 each  stage register load enables
o_flush_f  out  1  load a bubble into decode
o_flush_d  out  1  load a bubble into execute
o_bubble_w  out  1  load a bubble into rf-write
o_pc_sel_target  out  1  PC loads branch target instead of PC+1
o_rx_fwd_sel, o_ry_fwd_sel  out  2 each  0=RF, 1=from rf-write, 2=from execute
o_mem_req  out  1  memory request active
o_mem_err  out  1  sticky timeout error
o_state  out  2  0=RUN, 1=MEM_WAIT, 2=HALT
o_stall_cnt, o_flush_cnt, o_memwait_cnt  out  PERF_W each  performance counters

Behaviour:
- Reset (reset=1 at an edge): state=RUN, wait counter=0, o_mem_err=0, perf counters=0.
- While reset is high: all *_ld=1, o_flush_f=o_flush_d=o_bubble_w=1, o_mem_req=0, o_pc_sel_target=0. Pipeline loads bubbles.
- First cycle after release is normal RUN.
- Reset mid-MEM_WAIT or in HALT aborts the request; o_mem_req drops in the reset cycle.
- Forwarding (combinational, every state), per source s:
  - sel=2 if i_x_valid & i_x_wr_en & !i_x_is_load & i_x_wr_idx==s;
  - else sel=1 if i_w_valid & i_w_wr_en & i_w_wr_idx==s;
  - else 0.
  - Execute match has priority over rf-write match.
- RUN, default: all *_ld=1, no flush/bubble.
- Memory: o_mem_req = i_x_valid & i_x_is_mem in RUN and in MEM_WAIT.
  - If i_mem_ack arrives in the same RUN cycle: zero wait, normal advance.
  - Otherwise next state=MEM_WAIT.
- MEM_WAIT:
  - o_pc_ld=o_decode_ld=o_execute_ld=0; o_rfwrite_ld=1 with o_bubble_w=1.
  - Counter increments each cycle.
  - On i_mem_ack: that cycle acts as RUN (full advance, hazard checks apply); counter clears; next state=RUN.
  - If counter==MEM_TIMEOUT with no ack: next state=HALT, o_mem_err set.
- Load-use (RUN or the ack cycle):
  - Condition: i_x_valid & i_x_is_load & i_x_wr_en & i_d_valid & ((uses_rx & rx==wr_idx) | (uses_ry & ry==wr_idx)).
  - Response: o_pc_ld=o_decode_ld=0, o_execute_ld=1 with o_flush_d=1, o_rfwrite_ld=1. Exactly one stall cycle.
- Taken branch (RUN or the ack cycle, i_x_valid & i_x_br_taken):
  - o_pc_sel_target=1, o_flush_f=1, o_flush_d=1, all *_ld=1.
  - Overrides load-use stall; two younger instructions are killed.
- i_x_is_mem and i_x_br_taken asserted together is illegal; memory handling wins and the branch is ignored.
- HALT: all *_ld=0, o_mem_req=0, o_mem_err=1. Only reset exits.
- Precedence: reset > HALT > MEM_WAIT(no ack) > branch > load-use > normal.

Optional Feature:
CPU_PIPE_PERF_EN:
- Defined:
  - o_stall_cnt +1 per load-use stall cycle.
  - o_flush_cnt +1 per taken-branch flush.
  - o_memwait_cnt +1 per MEM_WAIT cycle.
  - All counters saturate at 2^PERF_W-1; cleared by reset.
- Undefined: ports remain, driven constant 0, no counter flops.

Decomposition:
- Package cpu_pipe_pkg:
  - state enum (RUN, MEM_WAIT, HALT);
  - forward-select constants FWD_RF=0, FWD_W=1, FWD_X=2.
- One sub-module, cpu_mem_wait_timer: wait counter, clear/enable, timeout flag, parametrised by MEM_TIMEOUT.

Test Plan:
- X writes r3 (ALU), W writes r3, D reads rx=r3 -> o_rx_fwd_sel=2. Remove X write -> 1. Neither -> 0.
- X load to r5, D uses ry=r5 -> one cycle: pc_ld=decode_ld=0, o_flush_d=1. Next cycle (load now in W, D still reads r5): o_ry_fwd_sel=1 and full advance.
- X store, i_mem_ack after 3 cycles -> 3 cycles MEM_WAIT with o_bubble_w=1, o_mem_req held. Ack cycle: all ld=1. State returns RUN.
- MEM_TIMEOUT=4, no ack -> state HALT after 5 wait cycles, o_mem_err=1, all ld=0. Reset clears it.
- Taken branch with load-use also true -> o_pc_sel_target=1, o_flush_f=o_flush_d=1, no stall.
- With CPU_PIPE_PERF_EN: run the above sequence; counters equal 1 stall, 1 flush, 3 memwait (excluding timeout run).
